// File: rtl/mul_inverse_div.sv
// Purpose : unsigned 32/16 restoring divider, the inverse of the c6288 16x16 multiplier.
// Latency : 17 cycles to done on a normal divide; 1 cycle on divide-by-zero or overflow.
// Backpres: ready=0 while dividing; a start seen then is dropped, not queued.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start, ready        request handshake; accepted on an edge with start=1 and ready=1
//   dividend, divisor   operands, latched on the accepting edge
//   busy, done          busy while iterating; done is a one-cycle result strobe
//   quotient, remainder results, valid when done=1 and held until the next accept
//   div_by_zero, overflow  error flags, valid and held alongside the results
module mul_inverse_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] dvs_q, dvs_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic        accept;
  logic [16:0] trial;
  logic [16:0] diff;
  logic        fits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    accept = start && (state_q != DIVIDE);

    // During DIVIDE quo_q doubles as the dividend low-half shifter: each step
    // pulls its MSB into the partial remainder and shifts a quotient bit in.
    // The trial value is 17 bits wide so the shifted-out remainder bit is kept.
    trial = {rem_q, quo_q[15]};
    diff  = trial - {1'b0, dvs_q};
    fits  = (trial >= {1'b0, dvs_q});

    case (state_q)
      DIVIDE: begin
        cnt_d = cnt_q - 5'd1;
        quo_d = {quo_q[14:0], fits};
        rem_d = fits ? diff[15:0] : trial[15:0];
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end
      end
      default: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (accept) begin
          dvs_d = divisor;
          if (divisor == 16'd0) begin
            state_d = DONE;
            cnt_d   = 5'd0;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            quo_d   = 16'hFFFF;
            rem_d   = 16'h0000;
          end else if (dividend[31:16] >= divisor) begin
            // Upper half already >= divisor means the quotient needs more than 16 bits.
            state_d = DONE;
            cnt_d   = 5'd0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            quo_d   = 16'hFFFF;
            rem_d   = 16'h0000;
          end else begin
            // Upper half is a valid starting remainder since it is below the divisor.
            state_d = DIVIDE;
            cnt_d   = 5'd16;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            quo_d   = dividend[15:0];
            rem_d   = dividend[31:16];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      quo_q   <= 16'd0;
      rem_q   <= 16'd0;
      dvs_q   <= 16'd0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready       = (state_q != DIVIDE);
  assign busy        = (state_q == DIVIDE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mul_inverse_div.sv
// Purpose : self-checking bench for mul_inverse_div using a result scoreboard.
// Latency : expects done 17 cycles after accept (normal) or 1 cycle (error cases).
// Backpres: issues start only while ready=1, except for a deliberate mid-divide poke.
module tb_mul_inverse_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mul_inverse_div dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] dd, input logic [15:0] dv);
    exp_t e;
    if (dv == 16'd0) begin
      e.q = 16'hFFFF; e.r = 16'h0000; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 1;
    end else if ((dd / {16'd0, dv}) > 32'h0000FFFF) begin
      e.q = 16'hFFFF; e.r = 16'h0000; e.dbz = 1'b0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      e.q   = 16'(dd / {16'd0, dv});
      e.r   = 16'(dd % {16'd0, dv});
      e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 17;
    end
    return e;
  endfunction

  // Called at a negedge with ready=1; returns at the negedge where done=1.
  // poke_at>0 raises start for one cycle at that busy cycle with junk operands.
  task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, input int poke_at);
    exp_t        e;
    int          cyc;
    int          busy_seen;
    logic [31:0] prod;
    sb.push_back(model(dd, dv));
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(negedge clk);
    cyc       = 1;
    busy_seen = 0;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = 16'($urandom);
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_seen++;
      start = (cyc == poke_at);
      if (cyc == poke_at) begin
        dividend = $urandom;
        divisor  = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done_latency", cyc, e.lat);
    chk("busy_cycles", busy_seen, (e.lat == 17) ? 16 : 0);
    chk("quotient", {16'd0, quotient}, {16'd0, e.q});
    chk("remainder", {16'd0, remainder}, {16'd0, e.r});
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
    if (dv != 16'd0 && div_by_zero === 1'b0 && overflow === 1'b0) begin
      prod = {16'd0, quotient} * {16'd0, dv} + {16'd0, remainder};
      chk("identity_q_dv_r", prod, dd);
      chk("rem_lt_divisor", {31'd0, (remainder < dv)}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] rdv;
    logic [31:0] rdd;

    rst      = 1'b1;
    start    = 1'b1;
    dividend = 32'h12345678;
    divisor  = 16'h0003;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q_r", {quotient, remainder}, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);

    // First edge with rst low and start high is the accepting edge.
    rst = 1'b0;
    run_op(32'hFFFE0001, 16'hFFFF, 0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("hold_q_idle", {16'd0, quotient}, 32'h0000FFFF);

    run_op(32'd100, 16'd7, 0);
    @(negedge clk);
    run_op(32'd0, 16'd5, 0);
    @(negedge clk);
    run_op(32'h12345678, 16'd0, 0);
    @(negedge clk);
    chk("hold_dbz_idle", {31'd0, div_by_zero}, 32'd1);
    run_op(32'h00050000, 16'h0005, 0);
    @(negedge clk);
    run_op(32'h0004FFFF, 16'h0005, 0);
    @(negedge clk);

    // Start pulse mid-divide must be ignored.
    run_op(32'd100, 16'd7, 5);
    @(negedge clk);

    // Back-to-back: start during DONE, including error-to-normal transitions.
    run_op(32'd1000, 16'd33, 0);
    run_op(32'h12345678, 16'd0, 0);
    run_op(32'h0001ABCD, 16'h0100, 0);
    run_op(32'h00090000, 16'h0002, 0);
    @(negedge clk);

    // Reset at busy cycle 8 aborts with no done pulse.
    start    = 1'b1;
    dividend = 32'h00012345;
    divisor  = 16'h0077;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_at_cycle8", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    chk("abort_q_r", {quotient, remainder}, 32'd0);
    chk("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    begin
      int dones = 0;
      repeat (20) begin
        @(negedge clk);
        if (done === 1'b1) dones++;
      end
      chk("abort_no_done", dones, 0);
    end

    // Random pairs, mostly in range, with occasional zero or overflowing divisors.
    for (int i = 0; i < 1000; i++) begin
      rdv = 16'($urandom_range(1, 65535));
      rdd = {16'($urandom_range(0, int'(rdv) - 1)), 16'($urandom)};
      if (i % 97 == 3) rdv = 16'd0;
      if (i % 89 == 5) rdd = {rdv, 16'($urandom)};
      run_op(rdd, rdv, 0);
      if (i % 2 == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
